// File: rtl/dimming_cmd_pkg.sv
// dimming_cmd_pkg: opcodes, ack/error codes, FSM states and status-byte layout
// shared by the dimming command executor and its shadow register bank.
package dimming_cmd_pkg;
  localparam logic [7:0] OP_SET_GAIN    = 8'h01;
  localparam logic [7:0] OP_SET_MODE    = 8'h02;
  localparam logic [7:0] OP_SET_THRESH  = 8'h03;
  localparam logic [7:0] OP_ENABLE      = 8'h04;
  localparam logic [7:0] OP_READ_STATUS = 8'h05;
  localparam logic [7:0] OP_SOFT_RESET  = 8'h06;

  localparam logic [7:0] ACK_OK  = 8'h5A;
  localparam logic [7:0] ACK_ERR = 8'hE0;

  localparam logic [2:0] E_NONE = 3'd0;
  localparam logic [2:0] E_CHK  = 3'd1;
  localparam logic [2:0] E_OP   = 3'd2;
  localparam logic [2:0] E_LEN  = 3'd3;
  localparam logic [2:0] E_VAL  = 3'd4;

  localparam int ST_EN   = 7;
  localparam int ST_MODE = 5;
  localparam int ST_PEND = 4;
  localparam int ST_OVR  = 3;
  localparam int ST_ERR  = 0;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_EXEC, S_ACK} state_t;
  typedef enum logic [2:0] {SEL_GAIN, SEL_MODE, SEL_THRESH, SEL_ENABLE, SEL_SOFT} sel_t;

  function automatic logic [7:0] req_len(input logic [7:0] code);
    return code == OP_SET_THRESH ? 8'd2 :
           (code == OP_READ_STATUS || code == OP_SOFT_RESET) ? 8'd0 : 8'd1;
  endfunction

  // Error checks in priority order: checksum, opcode, length, value.
  function automatic logic [2:0] cmd_err(input logic [7:0] code, input logic [7:0] len,
                                         input logic [31:0] p, input logic [7:0] chk);
    if ((code ^ len ^ p[7:0] ^ p[15:8] ^ p[23:16] ^ p[31:24]) != chk) return E_CHK;
    if (code == 8'h00 || code > OP_SOFT_RESET) return E_OP;
    if (len != req_len(code)) return E_LEN;
    if ((code == OP_SET_MODE && p[7:2] != 6'd0) || (code == OP_ENABLE && p[7:1] != 7'd0))
      return E_VAL;
    return E_NONE;
  endfunction
endpackage

// File: rtl/dimming_shadow_regs.sv
// dimming_shadow_regs: shadow/active dimming parameters, pending flag and
// vsync edge detect; shadow copies to active on each vsync rising edge.
module dimming_shadow_regs
  import dimming_cmd_pkg::*;
#(
  parameter logic [7:0]  GAIN_DEFAULT   = 8'h80,
  parameter logic [15:0] THRESH_DEFAULT = 16'd512,
  parameter logic [1:0]  MODE_DEFAULT   = 2'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wr,
  input  sel_t        i_sel,
  input  logic [15:0] i_data,
  input  logic        i_vsync,
  output logic        o_sh_enable,
  output logic [1:0]  o_sh_mode,
  output logic        o_pending,
  output logic [7:0]  o_act_gain,
  output logic [1:0]  o_act_mode,
  output logic [15:0] o_act_thresh,
  output logic        o_act_enable
);
  logic        r_vs_d, r_pending;
  logic [7:0]  r_sh_gain, r_act_gain;
  logic [1:0]  r_sh_mode, r_act_mode;
  logic [15:0] r_sh_thresh, r_act_thresh;
  logic        r_sh_enable, r_act_enable;
  logic        w_edge;

  assign w_edge = i_vsync & ~r_vs_d;

  // A write coincident with the edge lands in shadow only; pending stays set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d       <= 1'b0;
      r_pending    <= 1'b0;
      r_sh_gain    <= GAIN_DEFAULT;
      r_sh_mode    <= MODE_DEFAULT;
      r_sh_thresh  <= THRESH_DEFAULT;
      r_sh_enable  <= 1'b0;
      r_act_gain   <= GAIN_DEFAULT;
      r_act_mode   <= MODE_DEFAULT;
      r_act_thresh <= THRESH_DEFAULT;
      r_act_enable <= 1'b0;
    end else begin
      r_vs_d    <= i_vsync;
      r_pending <= i_wr | (r_pending & ~w_edge);
      if (w_edge) begin
        r_act_gain   <= r_sh_gain;
        r_act_mode   <= r_sh_mode;
        r_act_thresh <= r_sh_thresh;
        r_act_enable <= r_sh_enable;
      end
      if (i_wr) begin
        case (i_sel)
          SEL_GAIN:   r_sh_gain   <= i_data[7:0];
          SEL_MODE:   r_sh_mode   <= i_data[1:0];
          SEL_THRESH: r_sh_thresh <= i_data;
          SEL_ENABLE: r_sh_enable <= i_data[0];
          default: begin
            r_sh_gain   <= GAIN_DEFAULT;
            r_sh_mode   <= MODE_DEFAULT;
            r_sh_thresh <= THRESH_DEFAULT;
            r_sh_enable <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_sh_enable  = r_sh_enable;
  assign o_sh_mode    = r_sh_mode;
  assign o_pending    = r_pending;
  assign o_act_gain   = r_act_gain;
  assign o_act_mode   = r_act_mode;
  assign o_act_thresh = r_act_thresh;
  assign o_act_enable = r_act_enable;
endmodule

// File: rtl/dimming_cmd_exec.sv
// dimming_cmd_exec: validates decoded UART commands, writes dimming shadow
// registers and returns one ack/status byte per command.
module dimming_cmd_exec
  import dimming_cmd_pkg::*;
#(
  parameter logic [7:0]  GAIN_DEFAULT   = 8'h80,
  parameter logic [15:0] THRESH_DEFAULT = 16'd512,
  parameter logic [1:0]  MODE_DEFAULT   = 2'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_vaild,
  input  logic [7:0]  cmdcode,
  input  logic [7:0]  cmd_len,
  input  logic [31:0] para_list_fixed,
  input  logic [7:0]  check,
  input  logic        vsync,
  input  logic        ack_ready,
  output logic        ack_valid,
  output logic [7:0]  ack_data,
  output logic        busy,
  output logic [7:0]  act_gain,
  output logic [1:0]  act_mode,
  output logic [15:0] act_thresh,
  output logic        act_enable
);
  state_t      r_state;
  logic [7:0]  r_code, r_len, r_chk, r_ack_data;
  logic [31:0] r_p;
  logic [2:0]  r_err, r_last_err;
  logic        r_overrun, r_ack_valid;
  logic        w_wr, w_sh_enable, w_pending;
  logic [1:0]  w_sh_mode;
  logic [7:0]  w_status;
  sel_t        w_sel;

  assign w_wr  = r_state == S_EXEC && r_err == E_NONE && r_code != OP_READ_STATUS;
  assign w_sel = r_code == OP_SET_GAIN   ? SEL_GAIN :
                 r_code == OP_SET_MODE   ? SEL_MODE :
                 r_code == OP_SET_THRESH ? SEL_THRESH :
                 r_code == OP_ENABLE     ? SEL_ENABLE : SEL_SOFT;

  always_comb begin
    w_status                = '0;
    w_status[ST_EN]         = w_sh_enable;
    w_status[ST_MODE +: 2]  = w_sh_mode;
    w_status[ST_PEND]       = w_pending;
    w_status[ST_OVR]        = r_overrun;
    w_status[ST_ERR +: 3]   = r_last_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_code      <= '0;
      r_len       <= '0;
      r_p         <= '0;
      r_chk       <= '0;
      r_err       <= E_NONE;
      r_last_err  <= E_NONE;
      r_overrun   <= 1'b0;
      r_ack_valid <= 1'b0;
      r_ack_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (cmd_vaild) begin
          r_code  <= cmdcode;
          r_len   <= cmd_len;
          r_p     <= para_list_fixed;
          r_chk   <= check;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_err   <= cmd_err(r_code, r_len, r_p, r_chk);
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_ack_valid <= 1'b1;
          r_ack_data  <= r_err != E_NONE ? (ACK_ERR | {5'd0, r_err}) :
                         r_code == OP_READ_STATUS ? w_status : ACK_OK;
          if (r_err != E_NONE) r_last_err <= r_err;
          else if (r_code == OP_READ_STATUS) r_overrun <= 1'b0;
          r_state <= S_ACK;
        end
        S_ACK: if (ack_ready) begin
          r_ack_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // A dropped command outranks the status-read clear of the same cycle.
      if (cmd_vaild && r_state != S_IDLE) r_overrun <= 1'b1;
    end
  end

  dimming_shadow_regs #(
    .GAIN_DEFAULT  (GAIN_DEFAULT),
    .THRESH_DEFAULT(THRESH_DEFAULT),
    .MODE_DEFAULT  (MODE_DEFAULT)
  ) u_regs (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr        (w_wr),
    .i_sel       (w_sel),
    .i_data      (r_p[15:0]),
    .i_vsync     (vsync),
    .o_sh_enable (w_sh_enable),
    .o_sh_mode   (w_sh_mode),
    .o_pending   (w_pending),
    .o_act_gain  (act_gain),
    .o_act_mode  (act_mode),
    .o_act_thresh(act_thresh),
    .o_act_enable(act_enable)
  );

  assign ack_valid = r_ack_valid;
  assign ack_data  = r_ack_data;
  assign busy      = r_state != S_IDLE;
endmodule

// File: doc/dimming_cmd_exec.md
# dimming_cmd_exec

Command executor that sits directly downstream of the UART command decoder. It consumes each decoded command (`cmdcode`, `cmd_len`, byte-swapped `para_list_fixed`, `check`, `cmd_vaild`), validates it, and writes local-dimming control parameters into shadow registers. Shadow registers are copied to active registers at the next frame boundary. One acknowledge/status byte is returned per command to the UART TX path over a valid/ready handshake.

## Interface
Parameters:
- `GAIN_DEFAULT`, 8'h80, reset/soft-reset value of gain
- `THRESH_DEFAULT`, 16'd512, reset/soft-reset value of zone threshold
- `MODE_DEFAULT`, 2'd0, reset/soft-reset value of dimming mode

Ports:
- `clk`  in  1  system clock; single clock domain
- `rst_n`  in  1  reset, asynchronous, active-low
- `cmd_vaild`  in  1  one-cycle pulse; command fields valid this cycle
- `cmdcode`  in  8  opcode
- `cmd_len`  in  8  parameter byte count
- `para_list_fixed`  in  32  parameters; byte 0 in [7:0]
- `check`  in  8  received checksum
- `vsync`  in  1  frame sync, same clock domain, active-high
- `ack_ready`  in  1  TX path accepts byte
- `ack_valid`  out  1  ack byte available
- `ack_data`  out  8  ack/status byte
- `busy`  out  1  FSM not in IDLE
- `act_gain`  out  8  active gain
- `act_mode`  out  2  active mode
- `act_thresh`  out  16  active zone threshold
- `act_enable`  out  1  active dimming enable

## Operation
- Checksum: `check` must equal `cmdcode ^ cmd_len ^ p[7:0] ^ p[15:8] ^ p[23:16] ^ p[31:24]`. All four parameter bytes are included regardless of `cmd_len`.
- Opcodes and required lengths:
  - 0x01 SET_GAIN, len 1: gain = p[7:0]
  - 0x02 SET_MODE, len 1: mode = p[1:0]; p[7:2] must be 0
  - 0x03 SET_THRESH, len 2: thresh = p[15:0]
  - 0x04 ENABLE, len 1: enable = p[0]; p[7:1] must be 0
  - 0x05 READ_STATUS, len 0: no write
  - 0x06 SOFT_RESET, len 0: shadow registers ← defaults, enable ← 0
- Error precedence: checksum error (0xE1), then bad opcode (0xE2), then bad length (0xE3), then bad value (0xE4). On any error no register is written and `last_err` is updated.
- Ack byte:
  - Success: 0x5A.
  - READ_STATUS success: status byte = {shadow enable, shadow mode[1:0], pending, overrun, last_err[2:0]}, where last_err is 0 for none and 1–4 for E1–E4.
  - READ_STATUS clears `overrun` after the byte is captured.
- FSM states: IDLE → CHECK → EXEC → ACK → IDLE.
  - IDLE: latch all fields on `cmd_vaild`.
  - CHECK: compute the error code.
  - EXEC: write the shadow register and form `ack_data`.
  - ACK: hold until `ack_valid && ack_ready`.
- A `cmd_vaild` pulse while not in IDLE is dropped and sets sticky `overrun`. The in-flight command is unaffected.
- Frame apply:
  - `vsync` rising edge is detected with one register stage.
  - On the edge, all active registers ← shadow and `pending` ← 0.
  - Any successful shadow write (including SOFT_RESET) sets `pending`.
- Simultaneous shadow write and vsync edge: active takes the pre-write shadow values and `pending` stays 1. The new value applies on the following edge.

## Timing
- Reset values:
  - Shadow and active registers: defaults, enable = 0.
  - `pending`, `overrun`, `last_err`: 0.
  - `ack_valid` = 0, `ack_data` = 0, `busy` = 0, FSM = IDLE.
- `cmd_vaild` at cycle N: CHECK at N+1, EXEC at N+2. Shadow write and `ack_valid`/`ack_data` are both visible at N+3.
- `ack_data` stays stable while `ack_valid` is high. `ack_valid` deasserts the cycle after the handshake completes.
- FSM is back in IDLE one cycle after the handshake, so the minimum command spacing is 4 cycles plus the ack wait.
- Active registers update 1 cycle after the `vsync` rising edge is sampled (edge-detect register).
- Reset asserted mid-command: immediate return to reset values; the pending ack is discarded.

## Structure
- Package `dimming_cmd_pkg` holds:
  - opcode constants
  - ack/error codes (0x5A, 0xE1–0xE4)
  - FSM state enum
  - status-byte bit positions
- Sub-module `dimming_shadow_regs` holds the shadow/active register pair, `pending`, and vsync edge detect. Its inputs are a write strobe, a select, and data.
- The FSM, checksum, and ack logic live in the top of this block.

## Test plan
- SET_GAIN: cmdcode 0x01, len 1, p=0x00000040, check 0x40 → ack 0x5A at N+3. `act_gain` stays 0x80 until vsync, then becomes 0x40.
- Bad checksum: SET_THRESH with p=0x00000300 and check 0x00 → ack 0xE1, shadow unchanged. READ_STATUS then returns last_err = 1.
- Bad value: SET_MODE with p=0x00000005 → ack 0xE4. Bad opcode 0x09 → ack 0xE2. ENABLE with len 2 → ack 0xE3.
- Backpressure and overrun: hold `ack_ready` = 0 for 20 cycles and issue a second `cmd_vaild` meanwhile. The second command is dropped. READ_STATUS shows overrun = 1; a second READ_STATUS shows overrun = 0.
- Write coincident with vsync edge: SET_GAIN 0x10 with its EXEC cycle aligned to the sampled vsync edge → active keeps the old gain and `pending` = 1. The next vsync applies 0x10.
- SOFT_RESET after several writes → ack 0x5A, shadow = defaults, enable = 0. Assert `rst_n` low during ACK → `ack_valid` drops immediately and outputs return to their reset values.
